program_counter: RTL
====================

// Module: program_counter
// PURPOSE
//  Upstream neighbour of instruction_fetch: owns the architectural PC and drives pc_out_i of the fetch stage.
//  Advances the PC by PC_INC on each accepted instruction-memory fetch (imem_ack_i), redirects on taken branches,
//  holds on stall and parks permanently on halt. Redirects arriving during a stall are buffered and applied later.
//  Keeps a saturating fetch counter for debug/performance.
// PARAMETERS
//  RESET_PC   0   PC value loaded on reset and held in IDLE
//  PC_INC     4   byte increment per fetched instruction (power of two, >=1)
//  CNT_WIDTH  32  width of fetch_cnt_o
//  ADDR_WIDTH comes from sp_pkg (not overridable here)
// PORTS
//  clk_i            in   1           clock, rising edge
//  arst_i           in   1           async reset, active-high
//  start_i          in   1           leave IDLE and begin fetching (level, sampled in IDLE only)
//  stall_i          in   1           hold PC (downstream not ready)
//  halt_i           in   1           stop fetching, enter HALT
//  branch_taken_i   in   1           redirect request, 1-cycle pulse
//  branch_target_i  in   ADDR_WIDTH  redirect address
//  imem_ack_i       in   1           fetch of current pc_o accepted by imem
//  pc_o             out  ADDR_WIDTH  current fetch address -> instruction_fetch.pc_out_i
//  pc_valid_o       out  1           pc_o is a live fetch address (state RUN)
//  misalign_o       out  1           1-cycle pulse: applied redirect target had low bits set
//  fetch_cnt_o      out  CNT_WIDTH   accepted fetches since reset, saturates at all-ones
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc_o=RESET_PC, pc_valid_o=0, misalign_o=0, fetch_cnt_o=0, pending cleared.
//  States: IDLE -> RUN when start_i=1; RUN -> HALT when halt_i=1; HALT exits only via arst_i.
//  IDLE/HALT: pc_o held, pc_valid_o=0; imem_ack_i, branch_taken_i, stall_i ignored; counter frozen.
//  RUN, priority per cycle (highest first):
//   1 halt_i=1: go HALT, pc_o held, pending redirect discarded, no count even if imem_ack_i=1.
//   2 stall_i=1: pc_o held; if branch_taken_i=1 store branch_target_i in pend_addr, pend_vld=1 (newer overwrites older).
//   3 branch_taken_i=1: pc_o <= aligned target next cycle, independent of imem_ack_i.
//   4 pend_vld=1: pc_o <= aligned pend_addr, pend_vld<=0.
//   5 imem_ack_i=1: pc_o <= pc_o + PC_INC, modulo 2^ADDR_WIDTH (wrap all-ones region to 0, no flag).
//   6 else hold.
//  Counting: fetch_cnt_o += 1 on every RUN cycle with imem_ack_i=1 and halt_i=0 and stall_i=0, including
//   cycles where a redirect wins (fetch still completed); saturates, never wraps.
//  Alignment: applied target has log2(PC_INC) LSBs forced to 0; misalign_o=1 the cycle after applying if any were set.
//  Latency: every pc_o update visible 1 cycle after the causing edge; no combinational input->output path.
//  pc_valid_o=1 from the cycle after start_i sampled in IDLE until HALT entry (deasserts same edge as state change).
//  start_i=1 with halt_i=1 in IDLE: go RUN (halt sampled only in RUN).
// TESTING  (ADDR_WIDTH=32, RESET_PC=0, PC_INC=4)
//  reset, start_i=1, imem_ack_i=1 for 3 cycles -> pc_o 0,4,8,0xC; fetch_cnt_o=3; pc_valid_o=1 from cycle after start.
//  RUN pc=0x10, branch_taken_i=1 target=0x100 with imem_ack_i=1 -> next pc_o=0x100, fetch_cnt_o+1, misalign_o=0.
//  stall_i=1 at pc=0x20, branch to 0x200 then 0x300 during stall, release stall -> pc 0x20 held, then 0x300 once.
//  pc=0xFFFF_FFFC, imem_ack_i=1 -> pc_o=0x0; branch target 0x103 -> pc_o=0x100, misalign_o pulses 1 cycle.
//  halt_i=1 with imem_ack_i=1 at pc=0x40 -> HALT, pc_o=0x40 held, count unchanged, later branches ignored.
//  arst_i mid-RUN at pc=0x80 with pend_vld=1 -> immediately pc_o=0, IDLE, pc_valid_o=0, cnt=0, no stale redirect.

Source files
------------

// File: rtl/program_counter_if.sv
//==============================================================================
// Module : sp_pkg / program_counter_if
// Brief  : Shared address width and the control/fetch bundle of program_counter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package sp_pkg;
    localparam int ADDR_WIDTH = 32;
endpackage

interface program_counter_if #(
    parameter int CNT_WIDTH = 32
);
    logic                          start_i;
    logic                          stall_i;
    logic                          halt_i;
    logic                          branch_taken_i;
    logic [sp_pkg::ADDR_WIDTH-1:0] branch_target_i;
    logic                          imem_ack_i;
    logic [sp_pkg::ADDR_WIDTH-1:0] pc_o;
    logic                          pc_valid_o;
    logic                          misalign_o;
    logic [CNT_WIDTH-1:0]          fetch_cnt_o;

    // Control side: sequencer / pipeline driving the PC block
    modport master (
        output start_i, stall_i, halt_i, branch_taken_i, branch_target_i, imem_ack_i,
        input  pc_o, pc_valid_o, misalign_o, fetch_cnt_o
    );

    modport slave (
        input  start_i, stall_i, halt_i, branch_taken_i, branch_target_i, imem_ack_i,
        output pc_o, pc_valid_o, misalign_o, fetch_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/program_counter.sv
//==============================================================================
// Module : program_counter
// Brief  : Architectural PC with stall-buffered redirects, halt parking and a
//          saturating accepted-fetch counter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module program_counter #(
    parameter logic [sp_pkg::ADDR_WIDTH-1:0] RESET_PC  = '0,
    parameter int                            PC_INC    = 4,
    parameter int                            CNT_WIDTH = 32
) (
    input  wire logic          clk_i,
    input  wire logic          arst_i,
    program_counter_if.slave   bus
);
    localparam int AW = sp_pkg::ADDR_WIDTH;
    localparam logic [AW-1:0] c_inc        = AW'(PC_INC);
    localparam logic [AW-1:0] c_align_low  = AW'(PC_INC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [AW-1:0]        r_pc,        w_pc_nxt;
    logic                 r_pend_vld,  w_pend_vld_nxt;
    logic [AW-1:0]        r_pend_addr, w_pend_addr_nxt;
    logic                 r_misalign,  w_misalign_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_cnt_inc;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_misalign  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_pend_addr <= w_pend_addr_nxt;
            r_misalign  <= w_misalign_nxt;
            if (w_cnt_inc && (r_cnt != {CNT_WIDTH{1'b1}}))
                r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_pend_vld_nxt  = r_pend_vld;
        w_pend_addr_nxt = r_pend_addr;
        w_misalign_nxt  = 1'b0;
        w_cnt_inc       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start_i)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bus.halt_i) begin
                    w_state_nxt    = S_HALT;
                    w_pend_vld_nxt = 1'b0;
                end else if (bus.stall_i) begin
                    if (bus.branch_taken_i) begin
                        w_pend_vld_nxt  = 1'b1;
                        w_pend_addr_nxt = bus.branch_target_i;
                    end
                end else begin
                    // Fetch completes even when a redirect wins the PC update
                    w_cnt_inc = bus.imem_ack_i;
                    if (bus.branch_taken_i) begin
                        // A live branch is newer than any buffered one, so drop the buffer
                        w_pc_nxt       = bus.branch_target_i & ~c_align_low;
                        w_misalign_nxt = |(bus.branch_target_i & c_align_low);
                        w_pend_vld_nxt = 1'b0;
                    end else if (r_pend_vld) begin
                        w_pc_nxt       = r_pend_addr & ~c_align_low;
                        w_misalign_nxt = |(r_pend_addr & c_align_low);
                        w_pend_vld_nxt = 1'b0;
                    end else if (bus.imem_ack_i) begin
                        w_pc_nxt = r_pc + c_inc;
                    end
                end
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.pc_o        = r_pc;
    assign bus.pc_valid_o  = (r_state == S_RUN);
    assign bus.misalign_o  = r_misalign;
    assign bus.fetch_cnt_o = r_cnt;

endmodule

`default_nettype wire
